// File: rtl/serial_pattern_tx.sv
// ============================================================================
// serial_pattern_tx
// Loads a bit pattern and shifts it out MSB-first on w, with optional
// back-to-back repeats and start/busy/done handshaking.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic [REP_W-1:0] repeats,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_idx,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_SHIFT = 3'b010;
  localparam logic [2:0] S_DONE  = 3'b100;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);

  logic [WIDTH-1:0] cap_pattern;
  logic [LEN_W-1:0] cap_len;
  logic [REP_W-1:0] cap_rep;
  logic [REP_W-1:0] pass_cnt;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] bit_sel;

  assign last_idx = cap_len - LEN_W'(1);
  assign bit_sel  = last_idx - bit_idx;

  // Mask-and-reduce selects the current bit without an over-wide index.
  assign w       = (state == S_SHIFT) && (|(cap_pattern & (WIDTH'(1) << bit_sel)));
  assign w_valid = (state == S_SHIFT);
  assign busy    = (state == S_SHIFT);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cap_pattern <= '0;
      cap_len     <= '0;
      cap_rep     <= '0;
      bit_idx     <= '0;
      pass_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (length != '0)) begin
            cap_pattern <= pattern;
            cap_len     <= (length > MAX_LEN) ? MAX_LEN : length;
            cap_rep     <= repeats;
            bit_idx     <= '0;
            pass_cnt    <= '0;
            state       <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            bit_idx <= '0;
            state   <= S_IDLE;
          end else if (bit_idx == last_idx) begin
            bit_idx <= '0;
            if (pass_cnt < cap_rep) begin
              pass_cnt <= pass_cnt + REP_W'(1);
            end else begin
              state <= S_DONE;
            end
          end else begin
            bit_idx <= bit_idx + LEN_W'(1);
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
// ============================================================================
// tb_serial_pattern_tx
// Directed and randomized checks of serial_pattern_tx against a queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] pattern;
  logic [3:0] length, repeats;
  logic       w, w_valid, busy, done;
  logic [3:0] bit_idx;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  // Model: queue of bits still to be sent (with their in-pass index).
  bit       m_bits[$];
  int       m_idx[$];
  bit       m_done = 1'b0;

  always #5 clk = ~clk;

  serial_pattern_tx dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .length(length), .repeats(repeats),
    .w(w), .w_valid(w_valid), .busy(busy), .done(done),
    .bit_idx(bit_idx), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int l;
    if (!reset) begin
      m_bits.delete(); m_idx.delete(); m_done = 1'b0;
    end else if (m_bits.size() != 0) begin
      if (abort) begin
        m_bits.delete(); m_idx.delete();
      end else begin
        void'(m_bits.pop_front()); void'(m_idx.pop_front());
        if (m_bits.size() == 0) m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start && length != 0) begin
      l = (length > 8) ? 8 : int'(length);
      for (int r = 0; r <= int'(repeats); r++)
        for (int i = 0; i < l; i++) begin
          m_bits.push_back(pattern[l-1-i]);
          m_idx.push_back(i);
        end
    end
  endtask

  task automatic check_outputs();
    bit act = (m_bits.size() != 0);
    chk("w_valid", w_valid, act);
    chk("busy", busy, act);
    chk("done", done, !act && m_done);
    chk("state", state, act ? 3'b010 : (m_done ? 3'b100 : 3'b001));
    chk("w", w, act ? m_bits[0] : 1'b0);
    if (act) chk("bit_idx", bit_idx, m_idx[0]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    pattern = p; length = l; repeats = r; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((m_bits.size() != 0 || m_done) && n < budget) begin
      tick(); n++;
    end
    chk("idle_reached", (m_bits.size() == 0 && !m_done), 1'b1);
    tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; abort = 1'b0;
    pattern = 8'hB2; length = 4'd8; repeats = 4'd0;
    // Reset held with start high
    for (int i = 0; i < 3; i++) tick();
    chk("reset_state", state, 3'b001);
    reset = 1'b1;
    tick();
    chk("shift_after_release", state, 3'b010);
    start = 1'b0;
    run_idle(40);

    // Single pass 1011_0010
    launch(8'hB2, 4'd8, 4'd0);
    run_idle(40);

    // Short pattern with repeats: 12 ones then done
    launch(8'h0F, 4'd4, 4'd2);
    for (int i = 1; i < 12; i++) begin
      chk("rep_w", w, 1'b1);
      tick();
    end
    chk("rep_last_w", w, 1'b1);
    tick();
    chk("rep_done", done, 1'b1);
    run_idle(10);

    // Abort at bit_idx 3
    launch(8'hAA, 4'd8, 4'd0);
    for (int i = 0; i < 10 && !(m_bits.size() != 0 && m_idx[0] == 3); i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", state, 3'b001);
    for (int i = 0; i < 4; i++) tick();

    // Ignored starts: length 0, and start during SHIFT
    launch(8'hFF, 4'd0, 4'd0);
    tick();
    chk("len0_busy", busy, 1'b0);
    launch(8'h5A, 4'd8, 4'd1);
    tick();
    pattern = 8'hFF; length = 4'd3; repeats = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    run_idle(40);

    // Mid-stream reset at bit_idx 5, then clamped length
    launch(8'hC3, 4'd8, 4'd0);
    for (int i = 0; i < 10 && !(m_bits.size() != 0 && m_idx[0] == 5); i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midreset_state", state, 3'b001);
    launch(8'h96, 4'd15, 4'd0);
    run_idle(40);

    // Randomized traffic, including held start and occasional abort/reset
    for (int t = 0; t < 40; t++) begin
      pattern = 8'($urandom); length = 4'($urandom); repeats = 4'($urandom_range(0, 3));
      start = ($urandom_range(0, 3) != 0);
      abort = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 31) != 0);
      for (int c = 0; c < int'($urandom_range(1, 12)); c++) begin
        tick();
        abort = ($urandom_range(0, 15) == 0);
        start = ($urandom_range(0, 2) == 0);
        if (start) pattern = 8'($urandom);
        reset = 1'b1;
      end
    end
    start = 1'b0; abort = 1'b0; reset = 1'b1;
    run_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
